// File: rtl/barrier_sequencer_if.sv
// Signal bundle between the barrier sequencer and its environment:
// barrier sprites, player lane input, frame sync and the HUD outputs.
interface barrier_sequencer_if;
    logic        i_v_sync;
    logic        i_start;
    logic        i_player_lane;
    logic        i_in_position_left;
    logic        i_in_position_right;
    logic        o_active_left;
    logic        o_active_right;
    logic [15:0] o_score;
    logic [1:0]  o_lives;
    logic        o_game_over;
    logic        o_hit_pulse;
    logic        o_dodge_pulse;

    // The sequencer itself
    modport slave (
        input  i_v_sync,
        input  i_start,
        input  i_player_lane,
        input  i_in_position_left,
        input  i_in_position_right,
        output o_active_left,
        output o_active_right,
        output o_score,
        output o_lives,
        output o_game_over,
        output o_hit_pulse,
        output o_dodge_pulse
    );

    // Whatever drives the sequencer (game top level or a bench)
    modport master (
        output i_v_sync,
        output i_start,
        output i_player_lane,
        output i_in_position_left,
        output i_in_position_right,
        input  o_active_left,
        input  o_active_right,
        input  o_score,
        input  o_lives,
        input  o_game_over,
        input  o_hit_pulse,
        input  o_dodge_pulse
    );
endinterface

// File: rtl/barrier_sequencer.sv
// Spawns left/right barriers on frame ticks, resolves each as hit or dodge,
// and keeps score, lives and game-over state.
module barrier_sequencer #(
    parameter int unsigned GAP_FRAMES    = 60,
    parameter int unsigned TRAVEL_FRAMES = 36,
    parameter int unsigned LIVES         = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    barrier_sequencer_if.slave bus
);
    localparam int unsigned MAX_FRAMES = (GAP_FRAMES > TRAVEL_FRAMES) ? GAP_FRAMES : TRAVEL_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES < 256) ? 8 : $clog2(MAX_FRAMES + 1);
    localparam logic [7:0]       SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [1:0]       LIVES_INIT  = 2'(LIVES);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_FRAMES);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_ACTIVE,
        S_RESOLVE,
        S_GAMEOVER
    } state_t;

    // Bit 0: v_sync, bit 1: left in_position, bit 2: right in_position
    logic [2:0]       w_async_in;
    logic [2:0]       r_meta;
    logic [2:0]       r_sync;
    logic             r_vs_prev;
    logic [7:0]       r_lfsr;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hit_flag;
    logic             r_side;
    logic             r_active_left;
    logic             r_active_right;
    logic [15:0]      r_score;
    logic [1:0]       r_lives;
    logic             r_game_over;
    logic             r_hit_pulse;
    logic             r_dodge_pulse;

    logic             w_frame_tick;
    logic             w_lfsr_fb;
    logic             w_side_in_pos;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_async_in    = {bus.i_in_position_right, bus.i_in_position_left, bus.i_v_sync};
    assign w_frame_tick  = r_sync[0] & ~r_vs_prev;
    assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_side_in_pos = r_side ? r_sync[2] : r_sync[1];
    assign w_cnt_inc     = r_cnt + 1'b1;

    // The off-side in_position never reaches this term, so it cannot score a hit
    assign w_hit = (r_state == S_ACTIVE) && w_side_in_pos &&
                   (bus.i_player_lane == r_side) && !r_hit_flag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta    <= 3'b000;
            r_sync    <= 3'b000;
            r_vs_prev <= 1'b0;
            r_lfsr    <= SEED;
        end else begin
            r_meta    <= w_async_in;
            r_sync    <= r_meta;
            r_vs_prev <= r_sync[0];
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_hit_flag     <= 1'b0;
            r_side         <= 1'b0;
            r_active_left  <= 1'b0;
            r_active_right <= 1'b0;
            r_score        <= 16'h0000;
            r_lives        <= LIVES_INIT;
            r_game_over    <= 1'b0;
            r_hit_pulse    <= 1'b0;
            r_dodge_pulse  <= 1'b0;
        end else begin
            r_hit_pulse   <= 1'b0;
            r_dodge_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= S_GAP;
                        r_score <= 16'h0000;
                        r_lives <= LIVES_INIT;
                        r_cnt   <= '0;
                    end
                end
                S_GAP: begin
                    if (w_frame_tick) begin
                        if (w_cnt_inc == GAP_LAST) begin
                            r_state        <= S_ACTIVE;
                            r_cnt          <= '0;
                            r_hit_flag     <= 1'b0;
                            r_side         <= r_lfsr[0];
                            r_active_left  <= ~r_lfsr[0];
                            r_active_right <= r_lfsr[0];
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_hit) begin
                        r_hit_flag  <= 1'b1;
                        r_hit_pulse <= 1'b1;
                        if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                    end
                    // Dodge is scored on entry so its pulse lines up with the RESOLVE cycle;
                    // a hit arriving on the final tick still suppresses it.
                    if (w_frame_tick) begin
                        if (w_cnt_inc == TRAVEL_LAST) begin
                            r_state        <= S_RESOLVE;
                            r_cnt          <= '0;
                            r_active_left  <= 1'b0;
                            r_active_right <= 1'b0;
                            if (!r_hit_flag && !w_hit) begin
                                r_dodge_pulse <= 1'b1;
                                if (r_score != 16'hFFFF) begin
                                    r_score <= r_score + 16'd1;
                                end
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_RESOLVE: begin
                    r_cnt <= '0;
                    if (r_lives == 2'd0) begin
                        r_state     <= S_GAMEOVER;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_GAMEOVER: begin
                    if (bus.i_start) begin
                        r_state     <= S_GAP;
                        r_game_over <= 1'b0;
                        r_score     <= 16'h0000;
                        r_lives     <= LIVES_INIT;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_active_left  = r_active_left;
    assign bus.o_active_right = r_active_right;
    assign bus.o_score        = r_score;
    assign bus.o_lives        = r_lives;
    assign bus.o_game_over    = r_game_over;
    assign bus.o_hit_pulse    = r_hit_pulse;
    assign bus.o_dodge_pulse  = r_dodge_pulse;

endmodule

// File: tb/tb_barrier_sequencer.sv
// Self-checking bench for barrier_sequencer: frame-level game model checked every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_barrier_sequencer;
    localparam int         GAP    = 2;
    localparam int         TRAVEL = 4;
    localparam int         NLIVES = 2;
    localparam logic [7:0] SEED   = 8'hA5;

    localparam int P_IDLE = 0, P_GAP = 1, P_ACTIVE = 2, P_RESOLVE = 3, P_OVER = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vs_period = 100;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural game model
    int         m_phase  = P_IDLE;
    int         m_frames = 0;
    bit         m_hit    = 1'b0;
    bit         m_side   = 1'b0;
    int         m_score  = 0;
    int         m_lives  = NLIVES;
    logic [7:0] m_lfsr   = SEED;
    bit         m_hitp   = 1'b0;
    bit         m_dodgep = 1'b0;
    bit [3:0]   vs_h     = '0;
    bit [2:0]   inl_h    = '0;
    bit [2:0]   inr_h    = '0;

    int obs_active = 0;
    int obs_hit    = 0;
    int obs_dodge  = 0;
    bit rst_done   = 1'b0;

    barrier_sequencer_if bus ();

    barrier_sequencer #(
        .GAP_FRAMES   (GAP),
        .TRAVEL_FRAMES(TRAVEL),
        .LIVES        (NLIVES),
        .LFSR_SEED    (SEED)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait expired, got no event, expected event within budget (t=%0t)", nm, $time);
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_frames = 0;
        m_hit    = 1'b0;
        m_side   = 1'b0;
        m_score  = 0;
        m_lives  = NLIVES;
        m_lfsr   = SEED;
        m_hitp   = 1'b0;
        m_dodgep = 1'b0;
        vs_h     = '0;
        inl_h    = '0;
        inr_h    = '0;
    endtask

    // Predicts the effect of the coming rising edge. Asynchronous inputs act two
    // edges after they are sampled (frame tick = synced v_sync rising edge).
    task automatic model_step();
        bit tick;
        bit pos;
        vs_h  = {vs_h[2:0], bus.i_v_sync};
        inl_h = {inl_h[1:0], bus.i_in_position_left};
        inr_h = {inr_h[1:0], bus.i_in_position_right};
        tick  = vs_h[2] && !vs_h[3];
        pos   = m_side ? inr_h[2] : inl_h[2];
        m_hitp   = 1'b0;
        m_dodgep = 1'b0;
        case (m_phase)
            P_IDLE, P_OVER: begin
                if (bus.i_start) begin
                    m_phase  = P_GAP;
                    m_score  = 0;
                    m_lives  = NLIVES;
                    m_frames = 0;
                end
            end
            P_GAP: begin
                if (tick) m_frames++;
                if (m_frames == GAP) begin
                    m_phase  = P_ACTIVE;
                    m_frames = 0;
                    m_hit    = 1'b0;
                    m_side   = m_lfsr[0];
                end
            end
            P_ACTIVE: begin
                if (!m_hit && pos && (bus.i_player_lane == m_side)) begin
                    m_hit  = 1'b1;
                    m_hitp = 1'b1;
                    if (m_lives > 0) m_lives--;
                end
                if (tick) m_frames++;
                if (m_frames == TRAVEL) begin
                    m_phase  = P_RESOLVE;
                    m_frames = 0;
                    if (!m_hit) begin
                        m_dodgep = 1'b1;
                        if (m_score < 65535) m_score++;
                    end
                end
            end
            default: begin
                m_phase = (m_lives == 0) ? P_OVER : P_GAP;
            end
        endcase
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    // Compare process: every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            chk("active_left",  32'(bus.o_active_left),  32'(m_phase == P_ACTIVE && !m_side));
            chk("active_right", 32'(bus.o_active_right), 32'(m_phase == P_ACTIVE && m_side));
            chk("both_active",  32'(bus.o_active_left & bus.o_active_right), 32'd0);
            chk("score",        32'(bus.o_score),        m_score);
            chk("lives",        32'(bus.o_lives),        m_lives);
            chk("game_over",    32'(bus.o_game_over),    32'(m_phase == P_OVER));
            chk("hit_pulse",    32'(bus.o_hit_pulse),    32'(m_hitp));
            chk("dodge_pulse",  32'(bus.o_dodge_pulse),  32'(m_dodgep));
            if (bus.o_active_left || bus.o_active_right) obs_active++;
            if (bus.o_hit_pulse) obs_hit++;
            if (bus.o_dodge_pulse) obs_dodge++;
            if (rst_n) model_step();
        end
    end

    // Frame sync source
    initial begin
        int ph;
        ph = 0;
        bus.i_v_sync = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph = (ph + 1 >= vs_period) ? 0 : ph + 1;
            bus.i_v_sync = (ph >= vs_period / 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_active(input string nm);
        int n;
        n = 0;
        while (!(bus.o_active_left || bus.o_active_right) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) timeout(nm);
    endtask

    task automatic wait_inactive(input string nm);
        int n;
        n = 0;
        while ((bus.o_active_left || bus.o_active_right) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) timeout(nm);
        step();
        step();
    endtask

    task automatic hit_barrier(input string nm);
        wait_active(nm);
        bus.i_player_lane = m_side;
        repeat (100) step();
        if (m_side) bus.i_in_position_right = 1'b1;
        else        bus.i_in_position_left  = 1'b1;
        repeat (100) step();
        bus.i_in_position_left  = 1'b0;
        bus.i_in_position_right = 1'b0;
        wait_inactive(nm);
    endtask

    initial begin
        int a0, h0, d0;
        bus.i_start             = 1'b0;
        bus.i_player_lane       = 1'b0;
        bus.i_in_position_left  = 1'b0;
        bus.i_in_position_right = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state, then 10 idle frames with start low
        chk("rst_lives", 32'(bus.o_lives), 32'd2);
        chk("rst_score", 32'(bus.o_score), 32'd0);
        repeat (1000) step();
        chk("idle_active_cycles", obs_active, 32'd0);
        chk("idle_lives", 32'(bus.o_lives), 32'd2);

        // First barrier dodged: player in the other lane, no in_position
        a0 = obs_active; h0 = obs_hit; d0 = obs_dodge;
        pulse_start();
        wait_active("s1_wait_active");
        bus.i_player_lane = ~m_side;
        wait_inactive("s1_wait_resolve");
        chk("s1_active_cycles", obs_active - a0, 32'd400);
        chk("s1_dodges", obs_dodge - d0, 32'd1);
        chk("s1_hits", obs_hit - h0, 32'd0);
        chk("s1_score", 32'(bus.o_score), 32'd1);

        // Hit: lane matches and in_position held for a whole frame -> one hit only
        h0 = obs_hit; d0 = obs_dodge;
        hit_barrier("s2_hit");
        chk("s2_hits", obs_hit - h0, 32'd1);
        chk("s2_dodges", obs_dodge - d0, 32'd0);
        chk("s2_lives", 32'(bus.o_lives), 32'd1);
        chk("s2_score", 32'(bus.o_score), 32'd1);

        // Second hit ends the game
        h0 = obs_hit;
        hit_barrier("s3_hit");
        chk("s3_hits", obs_hit - h0, 32'd1);
        chk("s3_lives", 32'(bus.o_lives), 32'd0);
        chk("s3_game_over", 32'(bus.o_game_over), 32'd1);
        a0 = obs_active;
        repeat (2000) step();
        chk("s3_over_active_cycles", obs_active - a0, 32'd0);
        chk("s3_over_hold", 32'(bus.o_game_over), 32'd1);
        pulse_start();
        chk("s3_restart_over", 32'(bus.o_game_over), 32'd0);
        chk("s3_restart_lives", 32'(bus.o_lives), 32'd2);
        chk("s3_restart_score", 32'(bus.o_score), 32'd0);

        // Score saturation from a preloaded value
        force dut.r_score = 16'hFFFE;
        m_score = 32'hFFFE;
        step();
        release dut.r_score;
        d0 = obs_dodge;
        wait_active("s4_wait_active1");
        bus.i_player_lane = ~m_side;
        wait_inactive("s4_wait_resolve1");
        chk("s4_score_first", 32'(bus.o_score), 32'hFFFF);
        wait_active("s4_wait_active2");
        // Off-side barrier reports in position with the player in that lane: not a hit
        bus.i_player_lane = ~m_side;
        if (m_side) bus.i_in_position_left  = 1'b1;
        else        bus.i_in_position_right = 1'b1;
        wait_inactive("s4_wait_resolve2");
        bus.i_in_position_left  = 1'b0;
        bus.i_in_position_right = 1'b0;
        chk("s4_score_sat", 32'(bus.o_score), 32'hFFFF);
        chk("s4_dodges", obs_dodge - d0, 32'd2);
        chk("s4_lives", 32'(bus.o_lives), 32'd2);

        // Random frames with a short frame period; one async reset mid right-side barrier
        vs_period = 8;
        for (int f = 0; f < 1000; f++) begin
            bus.i_start             = ($urandom_range(0, 3) == 0);
            bus.i_player_lane       = 1'($urandom_range(0, 1));
            bus.i_in_position_left  = 1'($urandom_range(0, 1));
            bus.i_in_position_right = 1'($urandom_range(0, 1));
            for (int c = 0; c < 8; c++) begin
                step();
                if (!rst_done && m_phase == P_ACTIVE && m_side && bus.o_active_right) begin
                    rst_n = 1'b0;
                    #1;
                    chk("arst_active_right", 32'(bus.o_active_right), 32'd0);
                    chk("arst_active_left",  32'(bus.o_active_left),  32'd0);
                    chk("arst_dodge",        32'(bus.o_dodge_pulse),  32'd0);
                    chk("arst_hit",          32'(bus.o_hit_pulse),    32'd0);
                    chk("arst_lives",        32'(bus.o_lives),        32'd2);
                    chk("arst_score",        32'(bus.o_score),        32'd0);
                    step();
                    rst_n    = 1'b1;
                    rst_done = 1'b1;
                end
            end
        end
        if (!rst_done) timeout("arst_right_barrier_seen");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
